// File: rtl/stopwatch_ctrl_if.sv
// Bus between the stopwatch control FSM and its surroundings: raw buttons,
// the live count from the time counter, and the counter/display controls.
interface stopwatch_ctrl_if;
    logic        i_btn_ss;
    logic        i_btn_lr;
    logic [23:0] i_count;
    logic        o_countenb;
    logic        o_countinit;
    logic [23:0] o_display;
    logic [7:0]  o_lap_num;
    logic [1:0]  o_state;

    // Environment side: drives buttons and count, observes controls.
    modport master (
        output i_btn_ss, i_btn_lr, i_count,
        input  o_countenb, o_countinit, o_display, o_lap_num, o_state
    );

    // Controller side.
    modport slave (
        input  i_btn_ss, i_btn_lr, i_count,
        output o_countenb, o_countinit, o_display, o_lap_num, o_state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: synchronises and debounces the Start/Stop and
// Lap/Reset buttons, sequences the BCD time counter (enable / clear),
// captures lap times and selects live or frozen time for the display.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int LAP_HOLD_TICKS = 200
) (
    input  logic            i_rtcclk,
    input  logic            rst,
    stopwatch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        CLEARED = 2'b00,
        RUNNING = 2'b01,
        LAP     = 2'b10,
        STOPPED = 2'b11
    } state_t;

    localparam logic [3:0] CNT_LAST  = 4'(DEBOUNCE_TICKS - 1);
    localparam logic [9:0] HOLD_LOAD = 10'(LAP_HOLD_TICKS - 1);

    // Bit 0 is Start/Stop, bit 1 is Lap/Reset throughout the button path.
    logic [1:0]      raw;
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [1:0]      level;
    logic [1:0]      level_q;
    logic [1:0]      press;
    logic [1:0][3:0] db_cnt;

    logic ss;
    logic lr;

    state_t      state, state_next;
    logic [23:0] lap_reg, lap_next;
    logic [7:0]  lap_num, lap_num_next;
    logic [9:0]  hold, hold_next;
    logic        countenb, countenb_next;
    logic        countinit, countinit_next;
    logic [23:0] display, display_next;

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = 8'h00;
        else if (v[3:0] == 4'h9)
            r = {v[7:4] + 4'h1, 4'h0};
        else
            r = {v[7:4], v[3:0] + 4'h1};
        return r;
    endfunction

    assign raw = {bus.i_btn_lr, bus.i_btn_ss};
    assign ss  = press[0];
    assign lr  = press[1];

    // Two-flop synchroniser for the asynchronous raw buttons.
    always_ff @(posedge i_rtcclk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 2'b00;
            sync_p1 <= 2'b00;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: level follows the synchronised input only after it has
    // disagreed for DEBOUNCE_TICKS consecutive cycles; agreement restarts.
    always_ff @(posedge i_rtcclk or posedge rst) begin
        if (rst) begin
            level  <= 2'b00;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] != level[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        level[i]  <= sync_p1[i];
                        db_cnt[i] <= 4'd0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 4'd1;
                    end
                end else begin
                    db_cnt[i] <= 4'd0;
                end
            end
        end
    end

    // Registered one-cycle press pulse on each debounced rising edge.
    always_ff @(posedge i_rtcclk or posedge rst) begin
        if (rst) begin
            level_q <= 2'b00;
            press   <= 2'b00;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

    // Next state, lap bookkeeping and next output values; Start/Stop
    // always has priority over Lap/Reset and over hold expiry.
    always_comb begin
        state_next     = state;
        lap_next       = lap_reg;
        lap_num_next   = lap_num;
        hold_next      = hold;
        countinit_next = 1'b0;
        case (state)
            CLEARED: begin
                if (ss)
                    state_next = RUNNING;
            end
            RUNNING: begin
                if (ss) begin
                    state_next = STOPPED;
                end else if (lr) begin
                    state_next   = LAP;
                    lap_next     = bus.i_count;
                    lap_num_next = bcd_inc(lap_num);
                    hold_next    = HOLD_LOAD;
                end
            end
            LAP: begin
                if (ss) begin
                    state_next = STOPPED;
                end else if (lr) begin
                    lap_next     = bus.i_count;
                    lap_num_next = bcd_inc(lap_num);
                    hold_next    = HOLD_LOAD;
                end else if (hold == 10'd0) begin
                    state_next = RUNNING;
                end else begin
                    hold_next = hold - 10'd1;
                end
            end
            STOPPED: begin
                if (ss) begin
                    state_next = RUNNING;
                end else if (lr) begin
                    state_next     = CLEARED;
                    countinit_next = 1'b1;
                    lap_next       = 24'h000000;
                    lap_num_next   = 8'h00;
                end
            end
            default: state_next = CLEARED;
        endcase
        countenb_next = (state_next == RUNNING) || (state_next == LAP);
        display_next  = (state_next == LAP) ? lap_next : bus.i_count;
    end

    // State, lap registers and all outputs update together.
    always_ff @(posedge i_rtcclk or posedge rst) begin
        if (rst) begin
            state     <= CLEARED;
            lap_reg   <= 24'h000000;
            lap_num   <= 8'h00;
            hold      <= 10'd0;
            countenb  <= 1'b0;
            countinit <= 1'b0;
            display   <= 24'h000000;
        end else begin
            state     <= state_next;
            lap_reg   <= lap_next;
            lap_num   <= lap_num_next;
            hold      <= hold_next;
            countenb  <= countenb_next;
            countinit <= countinit_next;
            display   <= display_next;
        end
    end

    assign bus.o_state     = state;
    assign bus.o_countenb  = countenb;
    assign bus.o_countinit = countinit;
    assign bus.o_display   = display;
    assign bus.o_lap_num   = lap_num;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with DEBOUNCE_TICKS=4, LAP_HOLD_TICKS=200.
module tb_stopwatch_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   init_seen;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.DEBOUNCE_TICKS(4), .LAP_HOLD_TICKS(200)) dut (
        .i_rtcclk (clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge and note any clear request seen there.
    task automatic tick();
        @(negedge clk);
        if (bus.o_countinit === 1'b1) init_seen++;
    endtask

    // Hold the chosen buttons for 10 cycles, then release and let them settle.
    task automatic press(input logic s, input logic l);
        bus.i_btn_ss = s;
        bus.i_btn_lr = l;
        repeat (10) tick();
        bus.i_btn_ss = 1'b0;
        bus.i_btn_lr = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_btn_ss = 1'b0;
        bus.i_btn_lr = 1'b0;
        bus.i_count  = 24'h111111;
        repeat (3) tick();
        checks++; if (bus.o_state !== 2'b00) begin failures++; $display("FAIL rst_state got %h want 0", bus.o_state); end
        checks++; if (bus.o_countenb !== 1'b0) begin failures++; $display("FAIL rst_countenb got %b want 0", bus.o_countenb); end
        checks++; if (bus.o_countinit !== 1'b0) begin failures++; $display("FAIL rst_countinit got %b want 0", bus.o_countinit); end
        checks++; if (bus.o_display !== 24'h0) begin failures++; $display("FAIL rst_display got %h want 0", bus.o_display); end
        checks++; if (bus.o_lap_num !== 8'h00) begin failures++; $display("FAIL rst_lap_num got %h want 00", bus.o_lap_num); end
        rst = 1'b0;
        tick();
        checks++; if (bus.o_state !== 2'b00) begin failures++; $display("FAIL rel_state got %h want 0", bus.o_state); end
        checks++; if (bus.o_countinit !== 1'b0) begin failures++; $display("FAIL rel_countinit got %b want 0", bus.o_countinit); end
        checks++; if (bus.o_display !== 24'h111111) begin failures++; $display("FAIL rel_display got %h want 111111", bus.o_display); end
    endtask

    task automatic test_debounce();
        bus.i_count = 24'h000042;
        bus.i_btn_ss = 1'b1;
        repeat (3) tick();
        bus.i_btn_ss = 1'b0;
        repeat (12) tick();
        checks++; if (bus.o_state !== 2'b00) begin failures++; $display("FAIL glitch_state got %h want 0", bus.o_state); end
        bus.i_btn_ss = 1'b1;
        repeat (7) tick();
        checks++; if (bus.o_state !== 2'b00) begin failures++; $display("FAIL lat_early_state got %h want 0", bus.o_state); end
        checks++; if (bus.o_countenb !== 1'b0) begin failures++; $display("FAIL lat_early_enb got %b want 0", bus.o_countenb); end
        tick();
        checks++; if (bus.o_state !== 2'b01) begin failures++; $display("FAIL lat_state got %h want 1", bus.o_state); end
        checks++; if (bus.o_countenb !== 1'b1) begin failures++; $display("FAIL lat_enb got %b want 1", bus.o_countenb); end
        repeat (2) tick();
        bus.i_btn_ss = 1'b0;
        repeat (20) tick();
        checks++; if (bus.o_state !== 2'b01) begin failures++; $display("FAIL hold_one_pulse got %h want 1", bus.o_state); end
        checks++; if (bus.o_display !== 24'h000042) begin failures++; $display("FAIL run_display got %h want 000042", bus.o_display); end
    endtask

    task automatic test_lap_capture();
        bus.i_count  = 24'h012345;
        bus.i_btn_lr = 1'b1;
        repeat (8) tick();
        checks++; if (bus.o_state !== 2'b10) begin failures++; $display("FAIL lap_state got %h want 2", bus.o_state); end
        checks++; if (bus.o_display !== 24'h012345) begin failures++; $display("FAIL lap_display got %h want 012345", bus.o_display); end
        checks++; if (bus.o_lap_num !== 8'h01) begin failures++; $display("FAIL lap_num got %h want 01", bus.o_lap_num); end
        checks++; if (bus.o_countenb !== 1'b1) begin failures++; $display("FAIL lap_enb got %b want 1", bus.o_countenb); end
        bus.i_btn_lr = 1'b0;
        bus.i_count  = 24'h999999;
        tick();
        checks++; if (bus.o_display !== 24'h012345) begin failures++; $display("FAIL lap_frozen got %h want 012345", bus.o_display); end
        bus.i_count = 24'h045678;
        repeat (198) tick();
        checks++; if (bus.o_state !== 2'b10) begin failures++; $display("FAIL hold_last got %h want 2", bus.o_state); end
        tick();
        checks++; if (bus.o_state !== 2'b01) begin failures++; $display("FAIL hold_expire got %h want 1", bus.o_state); end
        checks++; if (bus.o_display !== 24'h045678) begin failures++; $display("FAIL live_again got %h want 045678", bus.o_display); end
        bus.i_count = 24'h045679;
        tick();
        checks++; if (bus.o_display !== 24'h045679) begin failures++; $display("FAIL live_track got %h want 045679", bus.o_display); end
    endtask

    task automatic test_lap_count();
        repeat (8) press(1'b0, 1'b1);
        checks++; if (bus.o_lap_num !== 8'h09) begin failures++; $display("FAIL lap09 got %h want 09", bus.o_lap_num); end
        press(1'b0, 1'b1);
        checks++; if (bus.o_lap_num !== 8'h10) begin failures++; $display("FAIL lap10 got %h want 10", bus.o_lap_num); end
        checks++; if (bus.o_state !== 2'b10) begin failures++; $display("FAIL lap_stay got %h want 2", bus.o_state); end
        repeat (89) press(1'b0, 1'b1);
        checks++; if (bus.o_lap_num !== 8'h99) begin failures++; $display("FAIL lap99 got %h want 99", bus.o_lap_num); end
        bus.i_count = 24'h135790;
        press(1'b0, 1'b1);
        checks++; if (bus.o_lap_num !== 8'h00) begin failures++; $display("FAIL lap_wrap got %h want 00", bus.o_lap_num); end
        checks++; if (bus.o_display !== 24'h135790) begin failures++; $display("FAIL recapture got %h want 135790", bus.o_display); end
        repeat (200) tick();
        checks++; if (bus.o_state !== 2'b01) begin failures++; $display("FAIL back_run got %h want 1", bus.o_state); end
    endtask

    task automatic test_stop_clear();
        init_seen = 0;
        press(1'b1, 1'b0);
        checks++; if (bus.o_state !== 2'b11) begin failures++; $display("FAIL stop_state got %h want 3", bus.o_state); end
        checks++; if (bus.o_countenb !== 1'b0) begin failures++; $display("FAIL stop_enb got %b want 0", bus.o_countenb); end
        press(1'b1, 1'b0);
        checks++; if (bus.o_state !== 2'b01) begin failures++; $display("FAIL resume_state got %h want 1", bus.o_state); end
        checks++; if (bus.o_countenb !== 1'b1) begin failures++; $display("FAIL resume_enb got %b want 1", bus.o_countenb); end
        checks++; if (init_seen !== 0) begin failures++; $display("FAIL resume_noinit got %0d want 0", init_seen); end
        press(1'b1, 1'b0);
        bus.i_count  = 24'h002233;
        bus.i_btn_lr = 1'b1;
        repeat (7) tick();
        checks++; if (bus.o_state !== 2'b11) begin failures++; $display("FAIL preclr_state got %h want 3", bus.o_state); end
        tick();
        checks++; if (bus.o_state !== 2'b00) begin failures++; $display("FAIL clr_state got %h want 0", bus.o_state); end
        checks++; if (bus.o_countinit !== 1'b1) begin failures++; $display("FAIL clr_init got %b want 1", bus.o_countinit); end
        checks++; if (bus.o_lap_num !== 8'h00) begin failures++; $display("FAIL clr_lap got %h want 00", bus.o_lap_num); end
        checks++; if (bus.o_display !== 24'h002233) begin failures++; $display("FAIL clr_display got %h want 002233", bus.o_display); end
        tick();
        checks++; if (bus.o_countinit !== 1'b0) begin failures++; $display("FAIL clr_init_drop got %b want 0", bus.o_countinit); end
        bus.i_btn_lr = 1'b0;
        repeat (8) tick();
        checks++; if (init_seen !== 1) begin failures++; $display("FAIL init_once got %0d want 1", init_seen); end
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        checks++; if (bus.o_lap_num !== 8'h01) begin failures++; $display("FAIL sim_lap1 got %h want 01", bus.o_lap_num); end
        press(1'b1, 1'b1);
        checks++; if (bus.o_state !== 2'b11) begin failures++; $display("FAIL both_state got %h want 3", bus.o_state); end
        checks++; if (bus.o_lap_num !== 8'h01) begin failures++; $display("FAIL both_lap got %h want 01", bus.o_lap_num); end
        press(1'b1, 1'b0);
        bus.i_count  = 24'h000777;
        bus.i_btn_lr = 1'b1;
        repeat (8) tick();
        checks++; if (bus.o_lap_num !== 8'h02) begin failures++; $display("FAIL exp_lap2 got %h want 02", bus.o_lap_num); end
        repeat (2) tick();
        bus.i_btn_lr = 1'b0;
        repeat (190) tick();
        bus.i_count  = 24'h054321;
        bus.i_btn_lr = 1'b1;
        repeat (7) tick();
        checks++; if (bus.o_state !== 2'b10) begin failures++; $display("FAIL exp_pre got %h want 2", bus.o_state); end
        tick();
        checks++; if (bus.o_state !== 2'b10) begin failures++; $display("FAIL exp_pulse_wins got %h want 2", bus.o_state); end
        checks++; if (bus.o_lap_num !== 8'h03) begin failures++; $display("FAIL exp_lap3 got %h want 03", bus.o_lap_num); end
        checks++; if (bus.o_display !== 24'h054321) begin failures++; $display("FAIL exp_capture got %h want 054321", bus.o_display); end
        bus.i_btn_lr = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset_midop();
        bus.i_btn_ss = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.o_state !== 2'b00) begin failures++; $display("FAIL async_state got %h want 0", bus.o_state); end
        checks++; if (bus.o_countenb !== 1'b0) begin failures++; $display("FAIL async_enb got %b want 0", bus.o_countenb); end
        checks++; if (bus.o_display !== 24'h0) begin failures++; $display("FAIL async_display got %h want 0", bus.o_display); end
        checks++; if (bus.o_lap_num !== 8'h00) begin failures++; $display("FAIL async_lap got %h want 00", bus.o_lap_num); end
        checks++; if (bus.o_countinit !== 1'b0) begin failures++; $display("FAIL async_init got %b want 0", bus.o_countinit); end
        repeat (3) tick();
        rst = 1'b0;
        repeat (7) tick();
        checks++; if (bus.o_state !== 2'b00) begin failures++; $display("FAIL relhold_early got %h want 0", bus.o_state); end
        tick();
        checks++; if (bus.o_state !== 2'b01) begin failures++; $display("FAIL relhold_state got %h want 1", bus.o_state); end
        checks++; if (bus.o_countenb !== 1'b1) begin failures++; $display("FAIL relhold_enb got %b want 1", bus.o_countenb); end
        repeat (10) tick();
        bus.i_btn_ss = 1'b0;
        repeat (20) tick();
        checks++; if (bus.o_state !== 2'b01) begin failures++; $display("FAIL relhold_once got %h want 1", bus.o_state); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        init_seen = 0;
        test_reset();
        test_debounce();
        test_lap_capture();
        test_lap_count();
        test_stop_clear();
        test_simultaneous();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
